// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bundle for program_loader.
interface program_loader_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned PC_WIDTH          = 8
);
  logic [7:0]                   byteIn;
  logic                         byteValid;
  logic                         byteReady;
  logic                         memWriteEnable;
  logic [PC_WIDTH-1:0]          memAddress;
  logic [INSTRUCTION_WIDTH-1:0] memData;
  logic                         cpuHold;
  logic                         loadDone;
  logic                         loadError;

  // Byte source / observer side
  modport master (
    output byteIn, byteValid,
    input  byteReady, memWriteEnable, memAddress, memData, cpuHold, loadDone, loadError
  );

  // Loader side
  modport slave (
    input  byteIn, byteValid,
    output byteReady, memWriteEnable, memAddress, memData, cpuHold, loadDone, loadError
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: SYNC, count, MSB-first words -> instruction memory writes.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned PC_WIDTH          = 8,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES    = 1000
) (
  input  logic             clock,
  input  logic             isResetN,
  program_loader_if.slave  bus
);

  localparam int unsigned BYTES  = INSTRUCTION_WIDTH / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LENGTH, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  localparam state_t END_STATE = CHECK;
`else
  typedef enum logic [2:0] {IDLE, LENGTH, DATA, WRITE, DONE, ERROR} state_t;
  localparam state_t END_STATE = DONE;
`endif

  state_t                       state;
  state_t                       state_next;
  logic [INSTRUCTION_WIDTH-1:0] word;
  logic [BCNT_W-1:0]            byte_cnt;
  logic [7:0]                   remaining;
  logic [PC_WIDTH-1:0]          address;
  logic [TMR_W-1:0]             timer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                   sum;
`endif

  logic                         ready_q;
  logic                         we_q;
  logic [PC_WIDTH-1:0]          addr_q;
  logic [INSTRUCTION_WIDTH-1:0] data_q;
  logic                         hold_q;
  logic                         done_q;
  logic                         err_q;

  logic                         accept_c;
  logic                         sync_c;
  logic                         last_byte_c;
  logic                         timeout_c;
  logic                         timed_c;
  logic [INSTRUCTION_WIDTH-1:0] word_next_c;

  assign accept_c    = bus.byteValid & ready_q;
  assign sync_c      = (bus.byteIn == SYNC_BYTE);
  assign last_byte_c = (byte_cnt == BCNT_W'(BYTES - 1));
  assign timeout_c   = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign word_next_c = INSTRUCTION_WIDTH'({word, bus.byteIn});
`ifdef LOADER_CHECKSUM_EN
  assign timed_c     = (state == LENGTH) || (state == DATA) || (state == CHECK);
`else
  assign timed_c     = (state == LENGTH) || (state == DATA);
`endif

  // State register
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic; a silent timeout aborts the frame from any byte-waiting state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c && sync_c) state_next = LENGTH;
      end
      LENGTH: begin
        if (accept_c)       state_next = (bus.byteIn == 8'd0) ? END_STATE : DATA;
        else if (timeout_c) state_next = ERROR;
      end
      DATA: begin
        if (accept_c) begin
          if (last_byte_c) state_next = WRITE;
        end else if (timeout_c) begin
          state_next = ERROR;
        end
      end
      WRITE: begin
        state_next = (remaining == 8'd1) ? END_STATE : DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept_c)       state_next = (bus.byteIn == sum) ? DONE : ERROR;
        else if (timeout_c) state_next = ERROR;
      end
`endif
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from the upcoming state
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      word      <= '0;
      byte_cnt  <= '0;
      remaining <= '0;
      address   <= '0;
      timer     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= !(state_next inside {WRITE, DONE, ERROR});
      we_q    <= (state_next == WRITE);
      done_q  <= (state_next == DONE);

      if (accept_c || (state_next != state)) timer <= '0;
      else if (timed_c)                      timer <= timer + TMR_W'(1);

      if (state_next == DONE)  hold_q <= 1'b0;
      if (state_next == ERROR) err_q  <= 1'b1;

      case (state)
        IDLE: begin
          if (accept_c && sync_c) begin
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            address <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
          end
        end
        LENGTH: begin
          if (accept_c) begin
            remaining <= bus.byteIn;
            byte_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= bus.byteIn;
`endif
          end
        end
        DATA: begin
          if (accept_c) begin
            word <= word_next_c;
`ifdef LOADER_CHECKSUM_EN
            sum  <= sum + bus.byteIn;
`endif
            if (last_byte_c) begin
              byte_cnt <= '0;
              addr_q   <= address;
              data_q   <= word_next_c;
            end else begin
              byte_cnt <= byte_cnt + BCNT_W'(1);
            end
          end
        end
        WRITE: begin
          address   <= address + PC_WIDTH'(1);
          remaining <= remaining - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byteReady      = ready_q;
  assign bus.memWriteEnable = we_q;
  assign bus.memAddress     = addr_q;
  assign bus.memData        = data_q;
  assign bus.cpuHold        = hold_q;
  assign bus.loadDone       = done_q;
  assign bus.loadError      = err_q;

endmodule
